// File: rtl/ch0re_pkg.sv
// rtl/ch0re_pkg.sv - shared types and constants for the ch0re fetch path
package ch0re_pkg;

  localparam logic [31:0] RV_NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        misaligned;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ch0re_fifo_sync.sv
// rtl/ch0re_fifo_sync.sv - synchronous FIFO with flush; push and pop may coincide when full
module ch0re_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH[AW:0]);
  // A pop frees the head slot this cycle, so a full FIFO can still accept a push.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ch0re_ifetch.sv
// rtl/ch0re_ifetch.sv - instruction fetch: PC sequencing, imem requests, decode-side buffer
module ch0re_ifetch
  import ch0re_pkg::*;
#(
  parameter int          IMEM_DEPTH      = 2048,
  parameter int          IMEM_ADDR_WIDTH = $clog2(IMEM_DEPTH),
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          FIFO_DEPTH      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_redirect,
  input  logic [63:0]                i_redirect_pc,
  output logic                       o_imem_req,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [31:0]                i_imem_rdata,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [31:0]                o_instr,
  output logic [63:0]                o_pc,
  output logic                       o_misaligned
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] FIFO_DEPTH_W = FIFO_DEPTH[CW:0];

  logic [63:0]  fetch_pc;
  logic [63:0]  inflight_pc;
  logic         inflight;
  logic         halt;
  logic [CW-1:0] fifo_count;
  logic         fifo_empty;
  logic [CW:0]  outstanding;
  logic         pop;
  logic         slot_free;
  logic         pc_misaligned;
  logic         can_issue;
  logic         imem_req;
  logic         mis_push;
  logic         push;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign pop           = !fifo_empty && i_ready;
  assign outstanding   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign slot_free     = outstanding < FIFO_DEPTH_W;
  assign pc_misaligned = (fetch_pc[1:0] != 2'b00);

  // Gating with rst_n keeps the request low for the whole reset window.
  assign can_issue = rst_n && !halt && !i_redirect && slot_free;
  assign imem_req  = can_issue && !pc_misaligned;
  assign mis_push  = can_issue && pc_misaligned && !inflight;
  assign push      = !i_redirect && (inflight || mis_push);

  always_comb begin
    push_entry = '0;
    if (inflight) begin
      push_entry.instr = i_imem_rdata;
      push_entry.pc    = inflight_pc;
    end else begin
      push_entry.instr      = RV_NOP;
      push_entry.pc         = fetch_pc;
      push_entry.misaligned = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      halt        <= 1'b0;
    end else if (i_redirect) begin
      fetch_pc <= i_redirect_pc;
      inflight <= 1'b0;
      halt     <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + 64'd4;
        inflight_pc <= fetch_pc;
      end
      if (mis_push) begin
        halt <= 1'b1;
      end
    end
  end

  ch0re_fifo_sync #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (i_redirect),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign o_imem_req   = imem_req;
  assign o_imem_addr  = fetch_pc[IMEM_ADDR_WIDTH+1:2];
  assign o_valid      = !fifo_empty;
  assign o_instr      = o_valid ? head_entry.instr : 32'h0;
  assign o_pc         = o_valid ? head_entry.pc : 64'h0;
  assign o_misaligned = o_valid && head_entry.misaligned;

endmodule

// File: tb/tb_ch0re_ifetch.sv
// tb/tb_ch0re_ifetch.sv - directed bench for ch0re_ifetch
module tb_ch0re_ifetch;

  localparam int IMEM_DEPTH = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_redirect;
  logic [63:0]   i_redirect_pc;
  logic          o_imem_req;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   i_imem_rdata = 32'h0;
  logic          o_valid;
  logic          i_ready;
  logic [31:0]   o_instr;
  logic [63:0]   o_pc;
  logic          o_misaligned;

  int n_vec = 0;
  int n_bad = 0;

  ch0re_ifetch #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .RESET_PC   (64'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rdata  (i_imem_rdata),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_misaligned  (o_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {26'd0, a};
  endfunction

  function automatic logic [31:0] exp_instr(input logic [63:0] pc);
    return word_at(pc[7:2]);
  endfunction

  always @(posedge clk) begin
    if (o_imem_req) i_imem_rdata <= word_at(o_imem_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_head(input string tag, input logic [63:0] pc);
    chk({tag, ".valid"}, {63'd0, o_valid}, 64'd1);
    chk({tag, ".pc"}, o_pc, pc);
    chk({tag, ".instr"}, {32'd0, o_instr}, {32'd0, exp_instr(pc)});
    chk({tag, ".mis"}, {63'd0, o_misaligned}, 64'd0);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".valid"}, {63'd0, o_valid}, 64'd0);
    chk({tag, ".req"}, {63'd0, o_imem_req}, 64'd0);
    chk({tag, ".instr"}, {32'd0, o_instr}, 64'd0);
    chk({tag, ".pc"}, o_pc, 64'd0);
    chk({tag, ".mis"}, {63'd0, o_misaligned}, 64'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = 64'h0;
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_idle("reset");
    chk("reset.addr", {58'd0, o_imem_addr}, 64'd0);

    // Reset release: request in cycle 0, first entry in cycle 2
    rst_n = 1'b1;
    #1;
    chk("c0.req", {63'd0, o_imem_req}, 64'd1);
    chk("c0.addr", {58'd0, o_imem_addr}, 64'd0);
    chk("c0.valid", {63'd0, o_valid}, 64'd0);
    cyc(); #1;
    chk("c1.valid", {63'd0, o_valid}, 64'd0);
    chk("c1.addr", {58'd0, o_imem_addr}, 64'd1);
    cyc(); #1;
    expect_head("c2", 64'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc(); #1;
      expect_head("stream", 64'(4 * k));
    end

    // Decode stall for 5 cycles with head at 0x10
    i_ready = 1'b0;
    #1;
    chk("stall0.req", {63'd0, o_imem_req}, 64'd0);
    for (int s = 1; s <= 4; s++) begin
      cyc(); #1;
      expect_head("stall", 64'h10);
      chk("stall.req", {63'd0, o_imem_req}, 64'd0);
    end
    cyc();
    i_ready = 1'b1;
    #1;
    expect_head("rel0", 64'h10);
    chk("rel0.req", {63'd0, o_imem_req}, 64'd1);
    chk("rel0.addr", {58'd0, o_imem_addr}, 64'd6);
    for (int k = 1; k <= 3; k++) begin
      cyc(); #1;
      expect_head("rel", 64'(16 + 4 * k));
    end

    // Redirect to 0x40 with a response in flight
    cyc();
    i_redirect = 1'b1;
    i_redirect_pc = 64'h40;
    #1;
    chk("rd40.req", {63'd0, o_imem_req}, 64'd0);
    cyc();
    i_redirect = 1'b0;
    #1;
    chk("rd40.c1.valid", {63'd0, o_valid}, 64'd0);
    chk("rd40.c1.req", {63'd0, o_imem_req}, 64'd1);
    chk("rd40.c1.addr", {58'd0, o_imem_addr}, 64'h10);
    cyc(); #1;
    chk("rd40.c2.valid", {63'd0, o_valid}, 64'd0);
    cyc(); #1;
    expect_head("rd40.c3", 64'h40);
    cyc(); #1;
    expect_head("rd40.c4", 64'h44);

    // Address and PC wrap
    cyc();
    i_redirect = 1'b1;
    i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    cyc();
    i_redirect = 1'b0;
    #1;
    chk("wrap.addr", {58'd0, o_imem_addr}, 64'h3F);
    cyc(); #1;
    chk("wrap.c2.valid", {63'd0, o_valid}, 64'd0);
    cyc(); #1;
    expect_head("wrap.top", 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(); #1;
    expect_head("wrap.zero", 64'h0);

    // Misaligned redirect then halt
    cyc();
    i_redirect = 1'b1;
    i_redirect_pc = 64'h42;
    #1;
    cyc();
    i_redirect = 1'b0;
    #1;
    chk("mis.c1.req", {63'd0, o_imem_req}, 64'd0);
    chk("mis.c1.valid", {63'd0, o_valid}, 64'd0);
    cyc(); #1;
    chk("mis.valid", {63'd0, o_valid}, 64'd1);
    chk("mis.pc", o_pc, 64'h42);
    chk("mis.instr", {32'd0, o_instr}, 64'h13);
    chk("mis.flag", {63'd0, o_misaligned}, 64'd1);
    chk("mis.req", {63'd0, o_imem_req}, 64'd0);
    for (int h = 0; h < 3; h++) begin
      cyc(); #1;
      chk("halt.valid", {63'd0, o_valid}, 64'd0);
      chk("halt.req", {63'd0, o_imem_req}, 64'd0);
    end

    // Resume at 0x80
    cyc();
    i_redirect = 1'b1;
    i_redirect_pc = 64'h80;
    #1;
    chk("res.c0.req", {63'd0, o_imem_req}, 64'd0);
    cyc();
    i_redirect = 1'b0;
    #1;
    chk("res.c1.req", {63'd0, o_imem_req}, 64'd1);
    chk("res.c1.addr", {58'd0, o_imem_addr}, 64'h20);
    cyc(); #1;
    cyc(); #1;
    expect_head("res.c3", 64'h80);
    cyc(); #1;
    expect_head("res.c4", 64'h84);
    cyc(); #1;
    expect_head("res.c5", 64'h88);

    // Fill the FIFO, then redirect together with a pop
    i_ready = 1'b0;
    #1;
    chk("fill.req", {63'd0, o_imem_req}, 64'd0);
    cyc(); #1;
    expect_head("full", 64'h88);
    chk("full.req", {63'd0, o_imem_req}, 64'd0);
    i_ready = 1'b1;
    i_redirect = 1'b1;
    i_redirect_pc = 64'h20;
    #1;
    chk("rdfull.req", {63'd0, o_imem_req}, 64'd0);
    cyc();
    i_redirect = 1'b0;
    #1;
    chk("rdfull.c1.valid", {63'd0, o_valid}, 64'd0);
    chk("rdfull.c1.req", {63'd0, o_imem_req}, 64'd1);
    chk("rdfull.c1.addr", {58'd0, o_imem_addr}, 64'h8);
    cyc(); #1;
    chk("rdfull.c2.valid", {63'd0, o_valid}, 64'd0);
    cyc(); #1;
    expect_head("rdfull.c3", 64'h20);
    cyc(); #1;
    expect_head("rdfull.c4", 64'h24);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    expect_idle("areset");
    chk("areset.addr", {58'd0, o_imem_addr}, 64'd0);
    cyc(); #1;
    expect_idle("areset.hold");
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rerun.c0.req", {63'd0, o_imem_req}, 64'd1);
    chk("rerun.c0.addr", {58'd0, o_imem_addr}, 64'd0);
    chk("rerun.c0.valid", {63'd0, o_valid}, 64'd0);
    cyc(); #1;
    chk("rerun.c1.valid", {63'd0, o_valid}, 64'd0);
    cyc(); #1;
    expect_head("rerun.c2", 64'h0);
    cyc(); #1;
    expect_head("rerun.c3", 64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
